// File: rtl/exception_ctrl_pkg.sv
// Shared constants and types for the exception entry controller.
// Build option EXC_TRAP_EN (see exc_prio_enc) adds the trap source.
package exception_ctrl_pkg;

    localparam int unsigned RegWidth  = 32;
    localparam logic        RstEnable = 1'b1;

    localparam logic [RegWidth-1:0] EXC_CODE_INT  = 32'h0000_0001;
    localparam logic [RegWidth-1:0] EXC_CODE_SYS  = 32'h0000_0008;
    localparam logic [RegWidth-1:0] EXC_CODE_INV  = 32'h0000_000a;
    localparam logic [RegWidth-1:0] EXC_CODE_TRAP = 32'h0000_000d;
    localparam logic [RegWidth-1:0] EXC_CODE_OVF  = 32'h0000_000c;
    localparam logic [RegWidth-1:0] EXC_CODE_ERET = 32'h0000_000e;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned IM_LO      = 8;
    localparam int unsigned IM_HI      = 15;

    // Flush counter is sized for FLUSH_CYCLES up to 15
    localparam int unsigned CntWidth = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_DRAIN = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic syscall;
        logic invalid;
        logic trap;
        logic ovf;
        logic eret;
    } exc_flags_t;

endpackage

// File: rtl/exception_ctrl_if.sv
// MEM-stage / coprocessor0 facing signal bundle of the exception controller.
interface exception_ctrl_if;
    import exception_ctrl_pkg::*;

    logic                inst_valid_i;
    logic                stall_i;
    logic                exc_syscall_i;
    logic                exc_invalid_i;
    logic                exc_trap_i;
    logic                exc_ovf_i;
    logic                exc_eret_i;
    logic [RegWidth-1:0] inst_addr_i;
    logic                in_delayslot_i;
    logic [RegWidth-1:0] status_i;
    logic [RegWidth-1:0] cause_i;
    logic [RegWidth-1:0] epc_i;

    logic [RegWidth-1:0] except_type_o;
    logic [RegWidth-1:0] epc_addr_o;
    logic                in_delayslot_o;
    logic                flush_o;
    logic [RegWidth-1:0] new_pc_o;
    logic                busy_o;

    modport master (
        output inst_valid_i, stall_i, exc_syscall_i, exc_invalid_i, exc_trap_i,
               exc_ovf_i, exc_eret_i, inst_addr_i, in_delayslot_i,
               status_i, cause_i, epc_i,
        input  except_type_o, epc_addr_o, in_delayslot_o, flush_o, new_pc_o, busy_o
    );

    modport slave (
        input  inst_valid_i, stall_i, exc_syscall_i, exc_invalid_i, exc_trap_i,
               exc_ovf_i, exc_eret_i, inst_addr_i, in_delayslot_i,
               status_i, cause_i, epc_i,
        output except_type_o, epc_addr_o, in_delayslot_o, flush_o, new_pc_o, busy_o
    );

endinterface

// File: rtl/exception_ctrl_prio_enc.sv
// Combinational exception priority encoder: interrupt > syscall > invalid > trap > overflow > eret.
// The trap source is only honoured when EXC_TRAP_EN is defined.
module exc_prio_enc
    import exception_ctrl_pkg::*;
(
    input  exc_flags_t          flags,
    input  logic                int_take,
    output logic                hit_c,
    output logic [RegWidth-1:0] code_c,
    output logic                is_eret_c
);

`ifdef EXC_TRAP_EN
    logic trap_en_c;
    assign trap_en_c = flags.trap;
`else
    logic trap_en_c;
    logic unused_trap;
    assign trap_en_c   = 1'b0;
    assign unused_trap = flags.trap;
`endif

    always_comb begin
        hit_c     = 1'b1;
        code_c    = '0;
        is_eret_c = 1'b0;
        if (int_take)           code_c = EXC_CODE_INT;
        else if (flags.syscall) code_c = EXC_CODE_SYS;
        else if (flags.invalid) code_c = EXC_CODE_INV;
        else if (trap_en_c)     code_c = EXC_CODE_TRAP;
        else if (flags.ovf)     code_c = EXC_CODE_OVF;
        else if (flags.eret) begin
            code_c    = EXC_CODE_ERET;
            is_eret_c = 1'b1;
        end else begin
            hit_c = 1'b0;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt entry sequencer between MEM and coprocessor0: one-cycle code,
// then a fixed-length flush with redirect PC. Build option EXC_TRAP_EN enables traps.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [RegWidth-1:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned         FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    exception_ctrl_if.slave   bus
);

    localparam logic [CntWidth-1:0] FlushLoad = CntWidth'(FLUSH_CYCLES - 1);

    exc_state_e          state;
    logic [CntWidth-1:0] cnt;

    logic                int_take_c;
    logic                hit_c;
    logic                is_eret_c;
    logic                commit_c;
    logic [RegWidth-1:0] code_c;
    exc_flags_t          flags_c;

    // Only IM/IE/EXL of status and IP of cause take part in the decision
    logic unused_cp0;
    assign unused_cp0 = ^{bus.status_i[RegWidth-1:IM_HI+1], bus.status_i[IM_LO-1:2],
                          bus.cause_i[RegWidth-1:IM_HI+1], bus.cause_i[IM_LO-1:0]};

    always_comb begin
        int_take_c = (|(bus.cause_i[IM_HI:IM_LO] & bus.status_i[IM_HI:IM_LO]))
                     && bus.status_i[STATUS_IE] && !bus.status_i[STATUS_EXL];
        flags_c = '{syscall: bus.exc_syscall_i, invalid: bus.exc_invalid_i,
                    trap: bus.exc_trap_i, ovf: bus.exc_ovf_i, eret: bus.exc_eret_i};
    end

    exc_prio_enc u_prio_enc (
        .flags     (flags_c),
        .int_take  (int_take_c),
        .hit_c     (hit_c),
        .code_c    (code_c),
        .is_eret_c (is_eret_c)
    );

    assign commit_c = (state == ST_IDLE) && bus.inst_valid_i && !bus.stall_i && hit_c;

    // Sequencer with registered outputs; flush_o/busy_o track the next state
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            bus.except_type_o  <= '0;
            bus.epc_addr_o     <= '0;
            bus.in_delayslot_o <= 1'b0;
            bus.flush_o        <= 1'b0;
            bus.busy_o         <= 1'b0;
            bus.new_pc_o       <= EXC_VECTOR;
        end else begin
            bus.except_type_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (commit_c) begin
                        state              <= ST_ENTER;
                        bus.except_type_o  <= code_c;
                        bus.epc_addr_o     <= bus.inst_addr_i;
                        bus.in_delayslot_o <= bus.in_delayslot_i;
                        bus.new_pc_o       <= is_eret_c ? bus.epc_i : EXC_VECTOR;
                        bus.flush_o        <= 1'b1;
                        bus.busy_o         <= 1'b1;
                    end
                end
                ST_ENTER: begin
                    cnt <= FlushLoad;
                    if (FlushLoad != '0) begin
                        state <= ST_DRAIN;
                    end else begin
                        state       <= ST_IDLE;
                        bus.flush_o <= 1'b0;
                        bus.busy_o  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt <= CntWidth'(1)) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        bus.flush_o <= 1'b0;
                        bus.busy_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    cnt         <= '0;
                    bus.flush_o <= 1'b0;
                    bus.busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl (FLUSH_CYCLES=2, EXC_VECTOR=32'h20).
module tb_exception_ctrl;
    import exception_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exception_ctrl_if bus ();

    exception_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.inst_valid_i   = 1'b0;
        bus.stall_i        = 1'b0;
        bus.exc_syscall_i  = 1'b0;
        bus.exc_invalid_i  = 1'b0;
        bus.exc_trap_i     = 1'b0;
        bus.exc_ovf_i      = 1'b0;
        bus.exc_eret_i     = 1'b0;
        bus.inst_addr_i    = '0;
        bus.in_delayslot_i = 1'b0;
        bus.status_i       = '0;
        bus.cause_i        = '0;
        bus.epc_i          = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.except_type_o !== 32'h0) begin errors++; $display("FAIL rst_type got %h exp 0", bus.except_type_o); end
        checks++; if (bus.epc_addr_o !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", bus.epc_addr_o); end
        checks++; if (bus.in_delayslot_o !== 1'b0) begin errors++; $display("FAIL rst_ds got %b exp 0", bus.in_delayslot_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", bus.flush_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.new_pc_o !== 32'h20) begin errors++; $display("FAIL rst_newpc got %h exp 20", bus.new_pc_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        bus.inst_valid_i = 1'b1; bus.exc_ovf_i = 1'b1; bus.inst_addr_i = 32'h100;
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'hc) begin errors++; $display("FAIL ovf_type got %h exp c", bus.except_type_o); end
        checks++; if (bus.epc_addr_o !== 32'h100) begin errors++; $display("FAIL ovf_epc got %h exp 100", bus.epc_addr_o); end
        checks++; if (bus.in_delayslot_o !== 1'b0) begin errors++; $display("FAIL ovf_ds got %b exp 0", bus.in_delayslot_o); end
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL ovf_flush1 got %b exp 1", bus.flush_o); end
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b exp 1", bus.busy_o); end
        checks++; if (bus.new_pc_o !== 32'h20) begin errors++; $display("FAIL ovf_newpc got %h exp 20", bus.new_pc_o); end
        step();
        checks++; if (bus.except_type_o !== 32'h0) begin errors++; $display("FAIL ovf_type2 got %h exp 0", bus.except_type_o); end
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL ovf_flush2 got %b exp 1", bus.flush_o); end
        step();
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL ovf_flush3 got %b exp 0", bus.flush_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL ovf_idle_busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.epc_addr_o !== 32'h100) begin errors++; $display("FAIL ovf_epc_hold got %h exp 100", bus.epc_addr_o); end
    endtask

    task automatic test_sys_over_ovf();
        bus.inst_valid_i = 1'b1; bus.exc_syscall_i = 1'b1; bus.exc_ovf_i = 1'b1;
        bus.inst_addr_i = 32'h200; bus.in_delayslot_i = 1'b1;
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'h8) begin errors++; $display("FAIL sys_type got %h exp 8", bus.except_type_o); end
        checks++; if (bus.epc_addr_o !== 32'h200) begin errors++; $display("FAIL sys_epc got %h exp 200", bus.epc_addr_o); end
        checks++; if (bus.in_delayslot_o !== 1'b1) begin errors++; $display("FAIL sys_ds got %b exp 1", bus.in_delayslot_o); end
        step();
        step();
    endtask

    task automatic test_interrupt();
        bus.inst_valid_i = 1'b1; bus.inst_addr_i = 32'h300;
        bus.cause_i = 32'h0000_0400; bus.status_i = 32'h0000_0401;
        step();
        bus.cause_i = '0;
        bus.inst_valid_i = 1'b0;
        checks++; if (bus.except_type_o !== 32'h1) begin errors++; $display("FAIL int_type got %h exp 1", bus.except_type_o); end
        checks++; if (bus.epc_addr_o !== 32'h300) begin errors++; $display("FAIL int_epc got %h exp 300", bus.epc_addr_o); end
        step();
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL int_drain got %b exp 1", bus.flush_o); end
        step();
        bus.inst_valid_i = 1'b1; bus.cause_i = 32'h0000_0400; bus.status_i = 32'h0000_0403;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL int_exl_flush%0d got %b exp 0", i, bus.flush_o); end
        end
        clear_inputs();
    endtask

    task automatic test_eret();
        bus.inst_valid_i = 1'b1; bus.exc_eret_i = 1'b1; bus.epc_i = 32'h1234; bus.inst_addr_i = 32'h700;
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'he) begin errors++; $display("FAIL eret_type got %h exp e", bus.except_type_o); end
        checks++; if (bus.new_pc_o !== 32'h1234) begin errors++; $display("FAIL eret_newpc got %h exp 1234", bus.new_pc_o); end
        step();
        step();
        checks++; if (bus.new_pc_o !== 32'h1234) begin errors++; $display("FAIL eret_newpc_hold got %h exp 1234", bus.new_pc_o); end
    endtask

    task automatic test_stall();
        bus.inst_valid_i = 1'b1; bus.exc_ovf_i = 1'b1; bus.inst_addr_i = 32'h600; bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.flush_o !== 1'b0 || bus.except_type_o !== 32'h0) begin errors++; $display("FAIL stall_hold%0d got flush %b type %h exp 0 0", i, bus.flush_o, bus.except_type_o); end
        end
        bus.stall_i = 1'b0;
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'hc) begin errors++; $display("FAIL stall_release_type got %h exp c", bus.except_type_o); end
        checks++; if (bus.epc_addr_o !== 32'h600) begin errors++; $display("FAIL stall_release_epc got %h exp 600", bus.epc_addr_o); end
        step();
        step();
    endtask

    task automatic test_ignore_in_flush();
        bus.inst_valid_i = 1'b1; bus.exc_ovf_i = 1'b1; bus.inst_addr_i = 32'h500;
        step();
        bus.exc_ovf_i = 1'b0; bus.exc_syscall_i = 1'b1; bus.inst_addr_i = 32'h504;
        step();
        checks++; if (bus.except_type_o !== 32'h0) begin errors++; $display("FAIL ign_type got %h exp 0", bus.except_type_o); end
        step();
        clear_inputs();
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL ign_flush got %b exp 0", bus.flush_o); end
        checks++; if (bus.epc_addr_o !== 32'h500) begin errors++; $display("FAIL ign_epc got %h exp 500", bus.epc_addr_o); end
        step();
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL ign_after got %b exp 0", bus.flush_o); end
    endtask

    task automatic test_back_to_back();
        bus.inst_valid_i = 1'b1; bus.exc_ovf_i = 1'b1; bus.inst_addr_i = 32'h400;
        step();
        checks++; if (bus.epc_addr_o !== 32'h400) begin errors++; $display("FAIL b2b_epc1 got %h exp 400", bus.epc_addr_o); end
        bus.inst_addr_i = 32'h404;
        step();
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL b2b_flush2 got %b exp 1", bus.flush_o); end
        step();
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", bus.flush_o); end
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'hc || bus.epc_addr_o !== 32'h404) begin errors++; $display("FAIL b2b_second got type %h epc %h exp c 404", bus.except_type_o, bus.epc_addr_o); end
        step();
        step();
    endtask

    task automatic test_bubble_and_trap();
        bus.inst_valid_i = 1'b0; bus.exc_ovf_i = 1'b1; bus.inst_addr_i = 32'h880;
        step();
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL bubble_flush got %b exp 0", bus.flush_o); end
        clear_inputs();
        bus.inst_valid_i = 1'b1; bus.exc_invalid_i = 1'b1; bus.exc_trap_i = 1'b1; bus.inst_addr_i = 32'h8a0;
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'ha) begin errors++; $display("FAIL inv_over_trap got %h exp a", bus.except_type_o); end
        step();
        step();
        bus.inst_valid_i = 1'b1; bus.exc_trap_i = 1'b1; bus.inst_addr_i = 32'h800;
        step();
        clear_inputs();
`ifdef EXC_TRAP_EN
        checks++; if (bus.except_type_o !== 32'hd) begin errors++; $display("FAIL trap_type got %h exp d", bus.except_type_o); end
        step();
        step();
`else
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL trap_ignored got %b exp 0", bus.flush_o); end
`endif
    endtask

    task automatic test_reset_mid_drain();
        bus.inst_valid_i = 1'b1; bus.exc_invalid_i = 1'b1; bus.inst_addr_i = 32'h900; bus.in_delayslot_i = 1'b1;
        step();
        clear_inputs();
        checks++; if (bus.except_type_o !== 32'ha) begin errors++; $display("FAIL rmid_type got %h exp a", bus.except_type_o); end
        step();
        rst = 1'b1;
        step();
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rmid_flush got %b exp 0", bus.flush_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", bus.busy_o); end
        checks++; if (bus.epc_addr_o !== 32'h0) begin errors++; $display("FAIL rmid_epc got %h exp 0", bus.epc_addr_o); end
        checks++; if (bus.in_delayslot_o !== 1'b0) begin errors++; $display("FAIL rmid_ds got %b exp 0", bus.in_delayslot_o); end
        checks++; if (bus.new_pc_o !== 32'h20) begin errors++; $display("FAIL rmid_newpc got %h exp 20", bus.new_pc_o); end
        rst = 1'b0;
        step();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        clear_inputs();
        test_reset();
        test_overflow();
        test_sys_over_ovf();
        test_interrupt();
        test_eret();
        test_stall();
        test_ignore_in_flush();
        test_back_to_back();
        test_bubble_and_trap();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
